// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the parametrised skid-buffered pipeline stage.
// The state encoding doubles as the occupancy count, so one can be
// converted to the other without any lookup.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int OCC_W = 2;

    // Number of entries held in a given state.
    function automatic logic [OCC_W-1:0] state_to_occ(input pipe_state_e st);
        return OCC_W'(st);
    endfunction

endpackage

// File: rtl/pipe_stage_sat_cnt.sv
// Saturating up-counter with asynchronous active-low clear.
// Counts once per cycle while inc_i is high and holds at all-ones.
module pipe_stage_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: advance unless idle or already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Parametrised pipeline stage register with valid/ready handshake and a
// 2-entry skid buffer (main + skid). up_ready_o comes straight from the
// state register, so there is no combinational ready path through the stage.
// Stall freezes only the output side; irq/flush empties the stage.
// Optional feature: define PIPE_STAGE_PERF_EN to get saturating stall/flush
// performance counters; otherwise the perf outputs are tied to zero.
module pipe_stage_skid_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W  = 80,
    parameter int N_STALL = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_STALL-1:0] stall_i,
    input  logic               irq_i,
    input  logic               flush_i,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [DATA_W-1:0]  up_data_i,
    output logic               dn_valid_o,
    input  logic               dn_ready_i,
    output logic [DATA_W-1:0]  dn_data_o,
    output logic [1:0]         occupancy_o,
    output logic [CNT_W-1:0]   perf_stall_cnt_o,
    output logic [CNT_W-1:0]   perf_flush_cnt_o
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic stall;
    logic flush;
    logic take;
    logic accept;

    // An interrupt must be able to clear a stalled pipe, so it masks stall.
    assign stall  = (|stall_i) & ~irq_i;
    assign flush  = irq_i | flush_i;

    assign up_ready_o  = (state_q != ST_FULL);
    assign dn_valid_o  = (state_q != ST_EMPTY);
    // main is already zero when empty; the gate keeps that guarantee explicit.
    assign dn_data_o   = dn_valid_o ? main_q : '0;
    assign occupancy_o = state_to_occ(state_q);

    assign take   = dn_valid_o & dn_ready_i & ~stall;
    assign accept = up_valid_i & up_ready_o & ~flush;

    // Next-state and datapath steering; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = up_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        main_d = up_data_i;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = up_data_i;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_FULL: begin
                    // up_ready_o is low here, so only the drain side can move.
                    if (take) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State and payload registers; reset discards every held entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (dn_valid_o & stall),
        .cnt_o (perf_stall_cnt_o)
    );

    pipe_stage_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush),
        .cnt_o (perf_flush_cnt_o)
    );
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: reset, single beat, streaming,
// stall into skid, irq over stall, flush in EMPTY, async reset in FULL.
// Perf expectations follow PIPE_STAGE_PERF_EN (zero when undefined).
module tb_pipe_stage_skid_reg;

    localparam int DATA_W  = 80;
    localparam int N_STALL = 4;
    localparam int CNT_W   = 32;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_STALL-1:0] stall_i;
    logic               irq_i;
    logic               flush_i;
    logic               up_valid_i;
    logic               up_ready_o;
    logic [DATA_W-1:0]  up_data_i;
    logic               dn_valid_o;
    logic               dn_ready_i;
    logic [DATA_W-1:0]  dn_data_o;
    logic [1:0]         occupancy_o;
    logic [CNT_W-1:0]   perf_stall_cnt_o;
    logic [CNT_W-1:0]   perf_flush_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_W  (DATA_W),
        .N_STALL (N_STALL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .irq_i            (irq_i),
        .flush_i          (flush_i),
        .up_valid_i       (up_valid_i),
        .up_ready_o       (up_ready_o),
        .up_data_i        (up_data_i),
        .dn_valid_o       (dn_valid_o),
        .dn_ready_i       (dn_ready_i),
        .dn_data_o        (dn_data_o),
        .occupancy_o      (occupancy_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".vld"}, dn_valid_o, 1'b0);
        chk({tag, ".data"}, dn_data_o, '0);
        chk({tag, ".occ"}, occupancy_o, 2'd0);
        chk({tag, ".rdy"}, up_ready_o, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        stall_i    = '0;
        irq_i      = 1'b0;
        flush_i    = 1'b0;
        up_valid_i = 1'b0;
        up_data_i  = '0;
        dn_ready_i = 1'b0;
        #1;
        chk_empty("reset");
        chk("reset.pstall", perf_stall_cnt_o, '0);
        chk("reset.pflush", perf_flush_cnt_o, '0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_empty("post_reset");

        // Single beat, 1-cycle latency
        up_valid_i = 1'b1;
        up_data_i  = 80'h1234;
        cyc();
        chk("single.vld", dn_valid_o, 1'b1);
        chk("single.data", dn_data_o, 80'h1234);
        chk("single.occ", occupancy_o, 2'd1);
        up_valid_i = 1'b0;
        up_data_i  = '0;
        dn_ready_i = 1'b1;
        cyc();
        chk_empty("single.drain");

        // Back-to-back stream of 8 beats
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b.rdy%0d", i), up_ready_o, 1'b1);
            up_valid_i = 1'b1;
            up_data_i  = 80'h100 + DATA_W'(i);
            cyc();
            chk($sformatf("b2b.vld%0d", i), dn_valid_o, 1'b1);
            chk($sformatf("b2b.data%0d", i), dn_data_o, 80'h100 + DATA_W'(i));
            chk($sformatf("b2b.occ%0d", i), occupancy_o, 2'd1);
        end
        up_valid_i = 1'b0;
        cyc();
        chk_empty("b2b.drain");

        // Stall while streaming: second beat parks in skid
        up_valid_i = 1'b1;
        up_data_i  = 80'hA1;
        cyc();
        chk("stall.pre", dn_data_o, 80'hA1);
        stall_i    = 4'b0010;
        up_data_i  = 80'hB2;
        cyc();
        chk("stall.occ1", occupancy_o, 2'd2);
        chk("stall.rdy1", up_ready_o, 1'b0);
        chk("stall.data1", dn_data_o, 80'hA1);
        up_data_i  = 80'hC3;
        cyc();
        chk("stall.data2", dn_data_o, 80'hA1);
        chk("stall.occ2", occupancy_o, 2'd2);
        cyc();
        chk("stall.data3", dn_data_o, 80'hA1);
        chk("stall.rdy3", up_ready_o, 1'b0);
        stall_i = '0;
        cyc();
        chk("rel.data1", dn_data_o, 80'hB2);
        chk("rel.occ1", occupancy_o, 2'd1);
        chk("rel.rdy1", up_ready_o, 1'b1);
        chk("rel.pstall", perf_stall_cnt_o, PERF ? 32'd3 : 32'd0);
        cyc();
        chk("rel.data2", dn_data_o, 80'hC3);
        chk("rel.occ2", occupancy_o, 2'd1);
        up_valid_i = 1'b0;
        cyc();
        chk_empty("rel.drain");

        // FULL, then irq with every stall source asserted
        dn_ready_i = 1'b0;
        up_valid_i = 1'b1;
        up_data_i  = 80'hD4;
        cyc();
        up_data_i  = 80'hE5;
        cyc();
        chk("full.occ", occupancy_o, 2'd2);
        chk("full.data", dn_data_o, 80'hD4);
        irq_i   = 1'b1;
        stall_i = 4'b1111;
        cyc();
        chk_empty("irq");
        chk("irq.pflush", perf_flush_cnt_o, PERF ? 32'd1 : 32'd0);
        chk("irq.pstall", perf_stall_cnt_o, PERF ? 32'd3 : 32'd0);
        irq_i   = 1'b0;
        stall_i = '0;

        // Flush with a valid upstream beat in EMPTY: nothing accepted
        flush_i   = 1'b1;
        up_data_i = 80'hF6;
        cyc();
        chk_empty("flush");
        chk("flush.pflush", perf_flush_cnt_o, PERF ? 32'd2 : 32'd0);
        flush_i    = 1'b0;
        up_valid_i = 1'b0;
        cyc();
        chk_empty("flush.after");

        // Async reset in FULL
        up_valid_i = 1'b1;
        up_data_i  = 80'h77;
        cyc();
        up_data_i  = 80'h88;
        cyc();
        chk("prerst.occ", occupancy_o, 2'd2);
        up_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_empty("async_rst");
        chk("async_rst.pstall", perf_stall_cnt_o, '0);
        chk("async_rst.pflush", perf_flush_cnt_o, '0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_empty("rst_release");
        cyc();
        chk_empty("rst_release2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
